stim_sequencer: RTL
===================

Name: stim_sequencer

Overview:
- Programmable vector player that drives the A/B/C/D control and data bus of a Q-producing datapath and checks the returned Q[2:0].
- Holds up to DEPTH vectors, each with its expected Q.
- On start, plays the vectors one per clock, compares Q after a fixed latency, and reports mismatch count and first failing index.
- Sits in front of the DUT as its synthesizable driver, for on-chip self-test.

Parameters:
- DEPTH, 8, number of vector slots (power of 2).
- AW, 3, address width, equal to log2(DEPTH).
- LAT, 1, clock cycles from a vector appearing on A..D to the matching Q being sampled (1..4).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_en  in  1  write a vector slot.
- wr_addr  in  AW  slot index.
- wr_data  in  10  {A,B,C,D[3:0],expQ[2:0]} (bit 9 = A, bits 2:0 = expQ).
- num_vec  in  AW+1  vectors to play (0..DEPTH), sampled at start.
- start  in  1  one-cycle start request.
- Q  in  3  DUT result.
- A  out  1  driven control bit.
- B  out  1  driven control bit.
- C  out  1  driven control bit.
- D  out  4  driven data.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the run completes.
- err_cnt  out  4  mismatch count, saturating at 15.
- first_err  out  AW  index of the first mismatching vector.
- err_flag  out  1  at least one mismatch in the last run.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - A, B, C, D, busy, done, err_cnt, first_err and err_flag all go to 0.
  - Compare pipeline valids are cleared.
  - Memory contents are undefined.
- Memory: DEPTH x 10 bit, synchronous write on wr_en.
  - Writes are accepted only in IDLE; when busy=1 they are ignored.
- FSM states: IDLE, PLAY, DRAIN, DONE.
- IDLE:
  - A..D are held at 0.
  - A start with num_vec>0 clears err_cnt, err_flag and first_err, latches len=num_vec, sets ptr=0, then goes to PLAY.
  - A start with num_vec=0 clears the error outputs and goes to DONE; no vectors are played.
  - num_vec>DEPTH is clamped to DEPTH.
- PLAY:
  - Each clock, A..D are registered from mem[ptr], and {valid=1, idx=ptr, expQ} is pushed into an LAT-stage compare pipeline; ptr then increments.
  - After the edge that launches vector len-1, go to DRAIN.
  - Vector k is visible on A..D during cycles 1+k .. 1+k (one cycle each), counted from the first PLAY edge.
- Compare:
  - When a pipeline entry reaches stage LAT, Q is sampled on that rising edge.
  - If Q != expQ: err_cnt increments (saturating at 15) and err_flag is set. If this is the first error of the run, first_err takes idx.
- DRAIN:
  - A..D return to 0.
  - Zeros with valid=0 are shifted into the pipeline, so no extra compares occur.
  - After LAT cycles, once all valid entries have retired, go to DONE.
- DONE: done=1 for exactly one cycle, busy=0, then return to IDLE. err_cnt, err_flag and first_err hold until the next accepted start.
- busy is 1 in PLAY and DRAIN, and 0 in IDLE and DONE.
- start outside IDLE is ignored.
- start and wr_en in the same IDLE cycle: the write completes and the run starts. The written slot is readable by the first PLAY edge.
- Reset asserted mid-run aborts immediately: outputs go to 0 and no done pulse is produced.
- ptr wraps modulo DEPTH. With len=DEPTH the last index is DEPTH-1, with no overrun.

Test Plan:
- Load 4 vectors: {0,1,0,0001,q=1}, {0,1,0,0011,q=2}, {1,1,1,0100,q=3}, {1,1,1,1111,q=4}. Tie Q to a model that matches, LAT=1, num_vec=4, start -> A..D show the four vectors on consecutive cycles; busy for 5 cycles; done pulse; err_cnt=0; err_flag=0.
- Same program with expQ of slot 2 corrupted to 7 -> err_cnt=1, first_err=2, err_flag=1.
- All 8 slots with wrong expQ, num_vec=8 -> err_cnt=8, first_err=0. Then rerun 2 extra times without clearing -> err_cnt resets per run and equals 8 each time. A separate 16+ mismatch run with LAT=1 is not possible at DEPTH 8, so force saturation with DEPTH=16: err_cnt=15.
- num_vec=0, start -> done pulses on the second cycle after start; busy stays 0; A..D stay 0.
- start pulsed again during PLAY, and wr_en during PLAY -> both are ignored; playback and memory are unchanged (verify by a rerun).
- rst asserted two cycles into a num_vec=4 run -> A..D, busy and err_cnt are 0 immediately (async); no done pulse; a new start then works normally.

Source files
------------

// File: rtl/stim_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stim_sequencer
// Description : Programmable on-chip vector player. Holds DEPTH stimulus
//               vectors with their expected results, plays them one per clock
//               onto the A/B/C/D bus of a downstream datapath, samples the
//               returned Q a fixed LAT cycles later and accumulates a
//               mismatch count plus the index of the first failing vector.
//
// Ports       : clk        - system clock, rising edge
//               rst        - asynchronous reset, active high
//               wr_en      - write one vector slot (accepted only when idle)
//               wr_addr    - slot index
//               wr_data    - {A, B, C, D[3:0], expQ[2:0]}
//               num_vec    - number of vectors to play, sampled at start
//               start      - one-cycle run request
//               Q          - result returned by the datapath under test
//               A, B, C, D - driven stimulus
//               busy       - run in progress
//               done       - one-cycle completion pulse
//               err_cnt    - saturating mismatch count of the last run
//               first_err  - index of the first mismatching vector
//               err_flag   - at least one mismatch in the last run
//
// Revision    : 1.0 - initial release
// ============================================================================
module stim_sequencer #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int LAT   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [9:0]    wr_data,
    input  logic [AW:0]   num_vec,
    input  logic          start,
    input  logic [2:0]    Q,
    output logic          A,
    output logic          B,
    output logic          C,
    output logic [3:0]    D,
    output logic          busy,
    output logic          done,
    output logic [3:0]    err_cnt,
    output logic [AW-1:0] first_err,
    output logic          err_flag
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW:0] DEPTH_V  = (AW+1)'(DEPTH);
    localparam logic [1:0]  LAT_LAST = 2'(LAT - 1);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t        state_q,     state_d;
    logic [AW:0]   len_q,       len_d;
    logic [AW:0]   vcnt_q,      vcnt_d;      // vectors launched so far
    logic [1:0]    drain_q,     drain_d;
    logic [6:0]    abcd_q,      abcd_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic [3:0]    err_cnt_q,   err_cnt_d;
    logic [AW-1:0] first_err_q, first_err_d;
    logic          err_flag_q,  err_flag_d;

    // Compare pipeline; stage 0 is loaded on the launch edge, stage LAT-1
    // is the one checked against Q.
    logic          pv_q   [LAT];
    logic          pv_d   [LAT];
    logic [AW-1:0] pidx_q [LAT];
    logic [AW-1:0] pidx_d [LAT];
    logic [2:0]    pexp_q [LAT];
    logic [2:0]    pexp_d [LAT];

    logic [9:0]    mem [DEPTH];
    logic [9:0]    rd_vec;
    logic [AW-1:0] ptr;

    // ------------------------------------------------------------------------
    // Vector memory: written only while idle, no reset
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (wr_en && (state_q == S_IDLE)) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The low AW bits of the launch counter form the read pointer, which
    // wraps modulo DEPTH on its own.
    assign ptr    = vcnt_q[AW-1:0];
    assign rd_vec = mem[ptr];

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        vcnt_d      = vcnt_q;
        drain_d     = drain_q;
        abcd_d      = '0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        err_flag_d  = err_flag_q;
        done_d      = (state_q == S_DONE);

        // Default pipeline move: shift by one, bubble into stage 0
        pv_d[0]   = 1'b0;
        pidx_d[0] = '0;
        pexp_d[0] = '0;
        for (int i = 1; i < LAT; i++) begin
            pv_d[i]   = pv_q[i-1];
            pidx_d[i] = pidx_q[i-1];
            pexp_d[i] = pexp_q[i-1];
        end

        // Retire the oldest entry
        if (pv_q[LAT-1] && (Q != pexp_q[LAT-1])) begin
            if (err_cnt_q != 4'hF) begin
                err_cnt_d = err_cnt_q + 4'd1;
            end
            err_flag_d = 1'b1;
            if (!err_flag_q) begin
                first_err_d = pidx_q[LAT-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_cnt_d   = '0;
                    err_flag_d  = 1'b0;
                    first_err_d = '0;
                    vcnt_d      = '0;
                    if (num_vec == '0) begin
                        state_d = S_DONE;
                    end else begin
                        len_d   = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;
                        state_d = S_PLAY;
                    end
                end
            end
            S_PLAY: begin
                abcd_d    = rd_vec[9:3];
                pv_d[0]   = 1'b1;
                pidx_d[0] = ptr;
                pexp_d[0] = rd_vec[2:0];
                vcnt_d    = vcnt_q + 1'b1;
                if (vcnt_q == (len_q - 1'b1)) begin
                    drain_d = '0;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // The last launched vector retires on the LAT-th drain edge
                drain_d = drain_q + 2'd1;
                if (drain_q == LAT_LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_PLAY) || (state_d == S_DRAIN);
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            vcnt_q      <= '0;
            drain_q     <= '0;
            abcd_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            err_flag_q  <= 1'b0;
            for (int i = 0; i < LAT; i++) begin
                pv_q[i]   <= 1'b0;
                pidx_q[i] <= '0;
                pexp_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            vcnt_q      <= vcnt_d;
            drain_q     <= drain_d;
            abcd_q      <= abcd_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            err_flag_q  <= err_flag_d;
            for (int i = 0; i < LAT; i++) begin
                pv_q[i]   <= pv_d[i];
                pidx_q[i] <= pidx_d[i];
                pexp_q[i] <= pexp_d[i];
            end
        end
    end

    assign A         = abcd_q[6];
    assign B         = abcd_q[5];
    assign C         = abcd_q[4];
    assign D         = abcd_q[3:0];
    assign busy      = busy_q;
    assign done      = done_q;
    assign err_cnt   = err_cnt_q;
    assign first_err = first_err_q;
    assign err_flag  = err_flag_q;

endmodule
`default_nettype wire
